// File: rtl/flp_pair_sequencer_if.sv
// Exponent stream, first-stage adder and result handshake signals of the pair sequencer.
// master = sequencer side, slave = environment (upstream source, adder, downstream sink).
interface flp_pair_sequencer_if #(
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_WIDTH-1:0] in_exp;
  logic                  in_last;
  logic [MANT_WIDTH-1:0] add_exp1;
  logic [MANT_WIDTH-1:0] add_exp2;
  logic [EXP_WIDTH-1:0]  add_exp;
  logic [MANT_WIDTH-1:0] add_mant;
  logic                  out_valid;
  logic                  out_ready;
  logic [EXP_WIDTH-1:0]  out_exp;
  logic [MANT_WIDTH-1:0] out_mant;
  logic                  out_last;
  logic                  out_single;
  logic [CNT_WIDTH-1:0]  pair_count;

  modport master (
    input  in_valid, in_exp, in_last, add_exp, add_mant, out_ready,
    output in_ready, add_exp1, add_exp2, out_valid, out_exp, out_mant,
           out_last, out_single, pair_count
  );

  modport slave (
    output in_valid, in_exp, in_last, add_exp, add_mant, out_ready,
    input  in_ready, add_exp1, add_exp2, out_valid, out_exp, out_mant,
           out_last, out_single, pair_count
  );
endinterface

// File: rtl/flp_pair_sequencer.sv
// Pairs consecutive exponents for the shared first-stage FP adder, registers the sum and
// offers it downstream; a lone final exponent of an odd frame is passed through unpaired.
module flp_pair_sequencer #(
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter logic [MANT_WIDTH-1:0] SINGLE_MANT = MANT_WIDTH'(1)
) (
  input  logic                   clk,
  input  logic                   rst,
  flp_pair_sequencer_if.master   bus,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_ISSUE  = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MANT_WIDTH-1:0] reg_a_q, reg_a_d;
  logic [MANT_WIDTH-1:0] reg_b_q, reg_b_d;
  logic                  last_q, last_d;
  logic [EXP_WIDTH-1:0]  out_exp_q, out_exp_d;
  logic [MANT_WIDTH-1:0] out_mant_q, out_mant_d;
  logic                  out_last_q, out_last_d;
  logic                  out_single_q, out_single_d;
  logic [CNT_WIDTH-1:0]  pair_count_q, pair_count_d;

  always_comb begin
    state_d      = state_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    last_d       = last_q;
    out_exp_d    = out_exp_q;
    out_mant_d   = out_mant_q;
    out_last_d   = out_last_q;
    out_single_d = out_single_q;
    pair_count_d = pair_count_q;
    case (state_q)
      S_FIRST: begin
        if (bus.in_valid) begin
          reg_a_d = bus.in_exp;
          if (bus.in_last) begin
            out_exp_d    = EXP_WIDTH'(bus.in_exp);
            out_mant_d   = SINGLE_MANT;
            out_single_d = 1'b1;
            out_last_d   = 1'b1;
            state_d      = S_OUT;
          end else begin
            state_d = S_SECOND;
          end
        end
      end
      S_SECOND: begin
        if (bus.in_valid) begin
          reg_b_d = bus.in_exp;
          last_d  = bus.in_last;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Adder is purely combinational from reg_a/reg_b, so its result is valid here.
        out_exp_d    = bus.add_exp;
        out_mant_d   = bus.add_mant;
        out_last_d   = last_q;
        out_single_d = 1'b0;
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_FIRST;
          if (out_last_q)         pair_count_d = '0;
          else if (!(&pair_count_q)) pair_count_d = pair_count_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FIRST;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      last_q       <= 1'b0;
      out_exp_q    <= '0;
      out_mant_q   <= '0;
      out_last_q   <= 1'b0;
      out_single_q <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      last_q       <= last_d;
      out_exp_q    <= out_exp_d;
      out_mant_q   <= out_mant_d;
      out_last_q   <= out_last_d;
      out_single_q <= out_single_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign bus.in_ready   = (state_q == S_FIRST) || (state_q == S_SECOND);
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.add_exp1   = reg_a_q;
  assign bus.add_exp2   = reg_b_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_single = out_single_q;
  assign bus.pair_count = pair_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_flp_pair_sequencer.sv
// Bench for flp_pair_sequencer: stub adder, scoreboard of expected results, directed and
// random frames with backpressure, reset mid-pair and pair_count saturation (CNT_WIDTH=2).
module tb_flp_pair_sequencer;
  localparam int EW = 9;
  localparam int MW = 8;
  localparam int CW = 2;
  localparam int RW = EW + MW + 2;
  localparam logic [MW-1:0] SMANT = 8'h01;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       rand_bp;

  flp_pair_sequencer_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MW), .CNT_WIDTH(CW)) bus ();

  flp_pair_sequencer #(.EXP_WIDTH(EW), .MANT_WIDTH(MW), .CNT_WIDTH(CW), .SINGLE_MANT(SMANT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stub first-stage adder ----------------
  function automatic logic [EW+MW-1:0] adder(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    e = (a > b) ? {1'b0, a} : {1'b0, b};
    m = (a > b) ? (a - b - 8'd1) : (b - a + 8'h80);
    return {e, m};
  endfunction

  always_comb {bus.add_exp, bus.add_mant} = adder(bus.add_exp1, bus.add_exp2);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [RW-1:0] exp_q[$];
  logic          have_a;
  logic [MW-1:0] a_m;
  logic [CW-1:0] exp_cnt;

  task automatic model_accept(input logic [MW-1:0] e, input logic l);
    if (!have_a) begin
      if (l) exp_q.push_back({{1'b0, e}, SMANT, 1'b1, 1'b1});
      else begin
        have_a = 1'b1;
        a_m    = e;
      end
    end else begin
      exp_q.push_back({adder(a_m, e), l, 1'b0});
      have_a = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_cnt = '0;
    end else begin
      check("pair_count", 32'(bus.pair_count), 32'(exp_cnt));
      check("ready_valid_excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          check("result", 32'({bus.out_exp, bus.out_mant, bus.out_last, bus.out_single}),
                32'(exp_q.pop_front()));
        end
        if (bus.out_last)   exp_cnt = '0;
        else if (!(&exp_cnt)) exp_cnt = exp_cnt + 2'd1;
      end
    end
  end

  always @(negedge clk) if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);

  // ---------------- driver tasks ----------------
  task automatic send(input logic [MW-1:0] e, input logic l);
    logic acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_exp   = e;
    bus.in_last  = l;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    else      model_accept(e, l);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (dbg_state == 2'd0);
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] snap;

  initial begin
    rst           = 1'b1;
    rand_bp       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    have_a        = 1'b0;
    a_m           = '0;
    exp_cnt       = '0;
    repeat (3) @(negedge clk);

    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_exp",    32'(bus.out_exp),    32'd0);
    check("rst_out_mant",   32'(bus.out_mant),   32'd0);
    check("rst_out_last",   32'(bus.out_last),   32'd0);
    check("rst_out_single", 32'(bus.out_single), 32'd0);
    check("rst_pair_count", 32'(bus.pair_count), 32'd0);
    check("rst_add_exp1",   32'(bus.add_exp1),   32'd0);
    check("rst_add_exp2",   32'(bus.add_exp2),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pair 5,3 (last): operands in S_ISSUE, result one edge after accepting 3
    send(8'd5, 1'b0);
    send(8'd3, 1'b1);
    check("pair_state_issue", 32'(dbg_state),     32'd2);
    check("pair_add_exp1",    32'(bus.add_exp1),  32'd5);
    check("pair_add_exp2",    32'(bus.add_exp2),  32'd3);
    check("pair_valid_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("pair_valid_lat",   32'(bus.out_valid), 32'd1);
    check("pair_out_exp",     32'(bus.out_exp),   32'd5);
    check("pair_out_mant",    32'(bus.out_mant),  32'h01);
    wait_drain();
    check("pair_cnt_cleared", 32'(bus.pair_count), 32'd0);

    // Odd frame 7,2,9: paired result then single passthrough
    send(8'd7, 1'b0);
    send(8'd2, 1'b0);
    send(8'd9, 1'b1);
    check("single_valid_lat", 32'(bus.out_valid),  32'd1);
    check("single_flag",      32'(bus.out_single), 32'd1);
    check("single_exp",       32'(bus.out_exp),    32'd9);
    wait_drain();

    // Backpressure: outputs hold, no input accepted
    bus.out_ready = 1'b0;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    wait_out_valid();
    snap = 32'({bus.out_exp, bus.out_mant, bus.out_last, bus.out_single, bus.pair_count});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({bus.out_exp, bus.out_mant, bus.out_last, bus.out_single, bus.pair_count}), snap);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
      check("bp_valid",    32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    send(8'd1, 1'b1);
    wait_drain();

    // Order: 2 then 6 stays (2,6)
    send(8'd2, 1'b0);
    send(8'd6, 1'b1);
    check("order_add_exp1", 32'(bus.add_exp1), 32'd2);
    check("order_add_exp2", 32'(bus.add_exp2), 32'd6);
    wait_drain();

    // Reset mid-pair: held 4 is discarded
    send(8'd4, 1'b0);
    check("mid_state_second", 32'(dbg_state), 32'd1);
    rst    = 1'b1;
    have_a = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_state", 32'(dbg_state),     32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    check("rst_add_exp1_after", 32'(bus.add_exp1), 32'd1);
    check("rst_add_exp2_after", 32'(bus.add_exp2), 32'd1);
    wait_drain();

    // pair_count saturation (2-bit counter): 1,2,3,3,3 then cleared by last
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0);
      send(8'($urandom_range(0, 255)), 1'b0);
      wait_drain();
      check("cnt_sat", 32'(bus.pair_count), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    send(8'($urandom_range(0, 255)), 1'b0);
    send(8'($urandom_range(0, 255)), 1'b1);
    wait_drain();
    check("cnt_last_clear", 32'(bus.pair_count), 32'd0);

    // Random frames with random backpressure
    rand_bp = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) send(8'($urandom_range(0, 255)), (i == len - 1));
    end
    wait_drain();
    rand_bp       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
